multi_port_fifo: RTL and testbench
==================================

Name: multi_port_fifo

Overview:
Single-clock FIFO that accepts up to NW entries and releases up to NR entries per cycle. It is the successor to the single-entry sync FIFO, sized for the superscalar fetch-to-decode instruction buffer. Heads are presented combinationally, so the consumer can pop in the same cycle it sees the data. The block adds a non-power-of-2 depth, all-or-nothing multi-push, clamped multi-pop, a synchronous flush, programmable almost-full/almost-empty flags and a sticky error flag.

Parameters:
WIDTH, 32, data bits per entry
DEPTH, 16, number of entries; any value >= max(NW,NR,2); need not be a power of 2
NW, 2, maximum pushes per cycle (1..DEPTH)
NR, 2, maximum pops per cycle (1..DEPTH)
AF_LVL, DEPTH-NW, almost_full_o asserts when count >= AF_LVL
AE_LVL, NR, almost_empty_o asserts when count <= AE_LVL

Ports:
clk_i  in  1  clock, rising edge
rstn_i  in  1  asynchronous reset, active low
flush_i  in  1  synchronous clear of all contents
push_cnt_i  in  $clog2(NW+1)  number of entries requested to push
wdata_i  in  NW*WIDTH  push lanes; lane 0 (LSBs) is the oldest
push_ok_o  out  1  push accepted this cycle (combinational)
pop_cnt_i  in  $clog2(NR+1)  number of entries requested to pop
rdata_o  out  NR*WIDTH  lane i = entry at head+i (combinational)
rvalid_o  out  NR  bit i = (count > i)
count_o  out  $clog2(DEPTH+1)  occupancy (registered)
free_o  out  $clog2(DEPTH+1)  DEPTH - count_o
empty_o / full_o  out  1 each  count==0 / count==DEPTH
almost_full_o / almost_empty_o  out  1 each  threshold flags, combinational from count_o
err_o  out  1  sticky; set on rejected push or over-pop

Behaviour:
- Reset (async, rstn_i low): rptr=wptr=0, count=0, err_o=0, therefore empty_o=1, full_o=0, rvalid_o=0, almost_empty_o=1, almost_full_o=(AF_LVL==0). Memory is not reset. rdata_o is don't-care while the matching rvalid bit is low.
- Pop: n_pop = min(pop_cnt_i, count). If pop_cnt_i > count, set err_o. rptr advances n_pop, modulo DEPTH.
- Push: all-or-nothing. push_ok_o = (push_cnt_i <= free computed from the pre-pop count) && !flush_i.
  - Same-cycle pops do not free space for pushes.
  - A push of 0 is always ok.
  - Rejected push (push_cnt_i > free, not flush): nothing is written and err_o is set.
  - On accept, lane k is written to mem[(wptr+k) mod DEPTH] for k < push_cnt_i, and wptr advances push_cnt_i.
- No bypass: data pushed in cycle t becomes visible on rdata_o in cycle t+1.
- count_next = count + n_push - n_pop. Compute in CW+1 bits; the result is never out of range.
- Pointer wrap: p + n >= DEPTH ? p + n - DEPTH : p + n. Never use a power-of-2 mask.
- flush_i has priority over push and pop in the same cycle: pointers and count return to 0, push_ok_o=0, and err_o is not affected.
- err_o is cleared only by reset.
- Simultaneous push and pop at full: the push is rejected, since the pre-pop free is 0.
- Reset asserted mid-operation drops all entries immediately (async).
- Assertions: AF_LVL <= DEPTH, AE_LVL < DEPTH, NW <= DEPTH, NR <= DEPTH.

Decomposition:
- Package fifo_pkg: function ptr_adv(ptr, n, depth) for the modular advance, plus a count-width helper constant function.
- Sub-module fifo_ptr_adv: combinational modular advance, instantiated for rptr and wptr and for per-lane read/write addresses. It is small enough that inlining the function is also acceptable.
- Storage is a flop array. Write-decoding uses per-lane address compare.

Test Plan:
DEPTH=6, NW=2, NR=2, WIDTH=8 unless stated.
1. Reset, then idle -> count_o=0, empty_o=1, rvalid_o=2'b00, almost_empty_o=1, err_o=0.
2. Push 2 {A0,A1}, then 2 {A2,A3}, then 2 {A4,A5} -> count 2,4,6; full_o=1, almost_full_o from count 4. Next push 1 -> push_ok_o=0, err_o=1, count stays 6.
3. At full, pop 2 and push 2 {B0,B1} in the same cycle -> push rejected, count=4, rdata_o lanes = A2,A3.
4. Wrap: from count=4 (rptr=2, wptr=0 after wrap), pop 2 and push 2 {C0,C1} for 3 cycles -> FIFO order preserved across index 5→0, count stays 4, no err.
5. count=1 holding X, pop_cnt=2 -> X consumed, count=0, err_o=1, rvalid_o=00 next cycle.
6. count=3, flush_i=1 with push 2 and pop 1 in the same cycle -> count=0, push_ok_o=0, next-cycle empty_o=1. Assert rstn_i low mid-burst -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/multi_port_fifo_pkg.sv
// Shared helpers for the multi-port FIFO: counter widths and modular pointer advance.
package fifo_pkg;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Advance a pointer by n (n <= depth) with wrap at depth; depth need not be a power of 2.
    function automatic int unsigned ptr_adv(input int unsigned ptr,
                                            input int unsigned n,
                                            input int unsigned depth);
        return (ptr + n >= depth) ? ptr + n - depth : ptr + n;
    endfunction

endpackage

// File: rtl/multi_port_fifo_if.sv
// Push/pop/status bundle for multi_port_fifo; the slave modport is the FIFO side.
interface multi_port_fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int NW    = 2,
    parameter int NR    = 2
);
    localparam int PCW = cnt_width(NW);
    localparam int RCW = cnt_width(NR);
    localparam int CW  = cnt_width(DEPTH);

    logic                  flush_i;
    logic [PCW-1:0]        push_cnt_i;
    logic [NW*WIDTH-1:0]   wdata_i;
    logic                  push_ok_o;
    logic [RCW-1:0]        pop_cnt_i;
    logic [NR*WIDTH-1:0]   rdata_o;
    logic [NR-1:0]         rvalid_o;
    logic [CW-1:0]         count_o;
    logic [CW-1:0]         free_o;
    logic                  empty_o;
    logic                  full_o;
    logic                  almost_full_o;
    logic                  almost_empty_o;
    logic                  err_o;

    modport master (
        output flush_i, push_cnt_i, wdata_i, pop_cnt_i,
        input  push_ok_o, rdata_o, rvalid_o, count_o, free_o,
               empty_o, full_o, almost_full_o, almost_empty_o, err_o
    );

    modport slave (
        input  flush_i, push_cnt_i, wdata_i, pop_cnt_i,
        output push_ok_o, rdata_o, rvalid_o, count_o, free_o,
               empty_o, full_o, almost_full_o, almost_empty_o, err_o
    );

endinterface

// File: rtl/multi_port_fifo_ptr_adv.sv
// Combinational modular pointer advance used for read/write pointers and lane addresses.
module fifo_ptr_adv
    import fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PW    = 4,
    parameter int NBW   = 5
) (
    input  logic [PW-1:0]  ptr,
    input  logic [NBW-1:0] n,
    output logic [PW-1:0]  nxt
);

    assign nxt = PW'(ptr_adv(32'(ptr), 32'(n), 32'(DEPTH)));

endmodule

// File: rtl/multi_port_fifo.sv
// Single-clock FIFO with up to NW all-or-nothing pushes and up to NR clamped pops per cycle.
// Heads are presented combinationally; pushed data becomes visible the following cycle.
module multi_port_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int NW     = 2,
    parameter int NR     = 2,
    parameter int AF_LVL = DEPTH - NW,
    parameter int AE_LVL = NR
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    multi_port_fifo_if.slave  bus
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = cnt_width(DEPTH);
    localparam int PCW = cnt_width(NW);
    localparam int RCW = cnt_width(NR);

    if (AF_LVL > DEPTH) begin : g_af_chk
        $error("AF_LVL must not exceed DEPTH");
    end
    if (AE_LVL >= DEPTH) begin : g_ae_chk
        $error("AE_LVL must be below DEPTH");
    end
    if (NW > DEPTH || NR > DEPTH || NW < 1 || NR < 1) begin : g_lane_chk
        $error("NW and NR must lie in 1..DEPTH");
    end
    if (DEPTH < 2) begin : g_depth_chk
        $error("DEPTH must be at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rptr, wptr, rptr_nxt, wptr_nxt;
    logic [PW-1:0]    raddr [NR];
    logic [PW-1:0]    waddr [NW];
    logic [CW-1:0]    count, free, n_push, n_pop, count_next;
    logic             count_msb_unused;
    logic             push_ok, push_rej, over_pop, err;

    // Space is judged on the pre-pop count, so same-cycle pops never make room for a push.
    assign free     = CW'(DEPTH) - count;
    assign push_ok  = (CW'(bus.push_cnt_i) <= free) && !bus.flush_i;
    assign push_rej = !push_ok && !bus.flush_i;
    assign over_pop = CW'(bus.pop_cnt_i) > count;
    assign n_pop    = over_pop ? count : CW'(bus.pop_cnt_i);
    assign n_push   = push_ok ? CW'(bus.push_cnt_i) : '0;

    // One spare bit absorbs the intermediate sum; the final value always fits in CW bits.
    assign {count_msb_unused, count_next} = {1'b0, count} + {1'b0, n_push} - {1'b0, n_pop};

    fifo_ptr_adv #(.DEPTH(DEPTH), .PW(PW), .NBW(CW)) u_rptr_adv (
        .ptr(rptr), .n(n_pop), .nxt(rptr_nxt)
    );

    fifo_ptr_adv #(.DEPTH(DEPTH), .PW(PW), .NBW(CW)) u_wptr_adv (
        .ptr(wptr), .n(n_push), .nxt(wptr_nxt)
    );

    for (genvar r = 0; r < NR; r++) begin : g_rd
        fifo_ptr_adv #(.DEPTH(DEPTH), .PW(PW), .NBW(CW)) u_raddr (
            .ptr(rptr), .n(CW'(r)), .nxt(raddr[r])
        );
        assign bus.rdata_o[r*WIDTH +: WIDTH] = mem[raddr[r]];
        assign bus.rvalid_o[r]               = count > CW'(r);
    end

    for (genvar w = 0; w < NW; w++) begin : g_wr
        fifo_ptr_adv #(.DEPTH(DEPTH), .PW(PW), .NBW(CW)) u_waddr (
            .ptr(wptr), .n(CW'(w)), .nxt(waddr[w])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (bus.flush_i) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            rptr  <= rptr_nxt;
            wptr  <= wptr_nxt;
            count <= count_next;
            if (push_rej || over_pop) begin
                err <= 1'b1;
            end
        end
    end

    // NOTE: storage is deliberately left unreset; rvalid_o qualifies every lane, so stale contents are harmless.
    always_ff @(posedge clk_i) begin
        for (int e = 0; e < DEPTH; e++) begin
            for (int k = 0; k < NW; k++) begin
                if (push_ok && (PCW'(k) < bus.push_cnt_i) && (waddr[k] == PW'(e))) begin
                    mem[e] <= bus.wdata_i[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign bus.push_ok_o      = push_ok;
    assign bus.count_o        = count;
    assign bus.free_o         = free;
    assign bus.empty_o        = (count == '0);
    assign bus.full_o         = (count == CW'(DEPTH));
    assign bus.almost_full_o  = (count >= CW'(AF_LVL));
    assign bus.almost_empty_o = (count <= CW'(AE_LVL));
    assign bus.err_o          = err;

    // Pop-count width is fixed by the interface; referenced here so a mismatch shows up at elaboration.
    if ($bits(bus.pop_cnt_i) != RCW) begin : g_rcw_chk
        $error("pop_cnt_i width does not match NR");
    end

endmodule

// File: tb/tb_multi_port_fifo.sv
// Scoreboard bench for multi_port_fifo: directed scenarios then random traffic against a queue model.
module tb_multi_port_fifo;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 6;
    localparam int NW     = 2;
    localparam int NR     = 2;
    localparam int AF_LVL = DEPTH - NW;
    localparam int AE_LVL = NR;
    localparam int PCW    = $clog2(NW + 1);
    localparam int RCW    = $clog2(NR + 1);

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    multi_port_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NW(NW), .NR(NR)) bus ();

    multi_port_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NW(NW), .NR(NR), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)
    ) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: entries in FIFO order, occupancy and sticky error.
    logic [WIDTH-1:0] exp_q [$];
    int               mcount;
    bit               merr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        logic [NR-1:0] ev;
        for (int i = 0; i < NR; i++) ev[i] = (mcount > i);
        check("count",        32'(bus.count_o),        32'(mcount));
        check("free",         32'(bus.free_o),         32'(DEPTH - mcount));
        check("empty",        32'(bus.empty_o),        32'(mcount == 0));
        check("full",         32'(bus.full_o),         32'(mcount == DEPTH));
        check("almost_full",  32'(bus.almost_full_o),  32'(mcount >= AF_LVL));
        check("almost_empty", 32'(bus.almost_empty_o), 32'(mcount <= AE_LVL));
        check("rvalid",       32'(bus.rvalid_o),       32'(ev));
        check("err",          32'(bus.err_o),          32'(merr));
    endtask

    // One clock of stimulus; status is checked mid-cycle, the model advances after the edge.
    task automatic step(input bit f, input int pcnt, input logic [WIDTH-1:0] d0,
                        input logic [WIDTH-1:0] d1, input int pop);
        bit exp_ok;
        bus.flush_i    = f;
        bus.push_cnt_i = PCW'(pcnt);
        bus.wdata_i    = {d1, d0};
        bus.pop_cnt_i  = RCW'(pop);
        @(negedge clk);
        check_status();
        exp_ok = !f && (pcnt <= DEPTH - mcount);
        check("push_ok", 32'(bus.push_ok_o), 32'(exp_ok));
        @(posedge clk);
        #1;
        if (f) begin
            mcount = 0;
            exp_q.delete();
        end else begin
            int npop;
            npop = (pop < mcount) ? pop : mcount;
            if (pop > mcount) merr = 1'b1;
            if (pcnt <= DEPTH - mcount) begin
                if (pcnt >= 1) exp_q.push_back(d0);
                if (pcnt >= 2) exp_q.push_back(d1);
                mcount += pcnt;
            end else begin
                merr = 1'b1;
            end
            mcount -= npop;
        end
    endtask

    task automatic idle();
        step(1'b0, 0, '0, '0, 0);
    endtask

    // Reset is applied between edges and its effect is checked before any clock arrives.
    task automatic do_reset();
        rstn   = 1'b0;
        mcount = 0;
        merr   = 1'b0;
        exp_q.delete();
        #2;
        check_status();
        @(negedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Monitor: compares every valid head lane with the model, then retires the lanes consumed.
    always @(negedge clk) begin
        if (rstn) begin
            for (int i = 0; i < NR; i++) begin
                if (bus.rvalid_o[i]) begin
                    if (i < exp_q.size()) begin
                        check($sformatf("rdata_lane%0d", i),
                              32'(bus.rdata_o[i*WIDTH +: WIDTH]), 32'(exp_q[i]));
                    end else begin
                        checks++;
                        failures++;
                        $display("FAIL rdata_lane%0d actual=valid required=no_entry at %0t", i, $time);
                    end
                end
            end
            if (!bus.flush_i) begin
                for (int i = 0; i < NR; i++) begin
                    if (i < int'(bus.pop_cnt_i) && bus.rvalid_o[i] && exp_q.size() > 0) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.flush_i    = 1'b0;
        bus.push_cnt_i = '0;
        bus.wdata_i    = '0;
        bus.pop_cnt_i  = '0;
        mcount         = 0;
        merr           = 1'b0;
        do_reset();

        // Idle after reset.
        idle();
        idle();

        // Fill to full, then an over-capacity push is rejected.
        step(1'b0, 2, 8'hA0, 8'hA1, 0);
        step(1'b0, 2, 8'hA2, 8'hA3, 0);
        step(1'b0, 2, 8'hA4, 8'hA5, 0);
        step(1'b0, 1, 8'hEE, 8'h00, 0);
        idle();

        // Pop and push together at full: push rejected, heads become A2,A3.
        step(1'b0, 2, 8'hB0, 8'hB1, 2);
        idle();

        // Steady-state pop 2 / push 2 across the wrap point.
        step(1'b0, 2, 8'hC0, 8'hC1, 2);
        step(1'b0, 2, 8'hC2, 8'hC3, 2);
        step(1'b0, 2, 8'hC4, 8'hC5, 2);
        idle();

        // Over-pop on a single entry from a clean error state.
        do_reset();
        step(1'b0, 1, 8'h5A, 8'h00, 0);
        step(1'b0, 0, 8'h00, 8'h00, 2);
        idle();

        // Flush wins over simultaneous push and pop.
        do_reset();
        step(1'b0, 2, 8'hD0, 8'hD1, 0);
        step(1'b0, 1, 8'hD2, 8'h00, 0);
        step(1'b1, 2, 8'hD3, 8'hD4, 1);
        idle();
        step(1'b0, 2, 8'hE0, 8'hE1, 0);
        idle();

        // Asynchronous reset in the middle of traffic.
        step(1'b0, 2, 8'hF0, 8'hF1, 0);
        step(1'b0, 2, 8'hF2, 8'hF3, 1);
        do_reset();
        idle();

        // Randomised traffic with occasional flush and reset.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 24) == 0,
                     int'($urandom_range(0, NW)),
                     WIDTH'($urandom), WIDTH'($urandom),
                     int'($urandom_range(0, NR)));
            end
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
